// File: rtl/conv_pkg.sv
// Shared types, widths and helpers for the kernel convolver.
// CONV_CHROMA_KEEP_EN selects chroma pass-through in kernel_convolver.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_e;

  localparam int unsigned COEF_W = 8;
  localparam int unsigned PIX_W  = 10;
  localparam logic [PIX_W-1:0] CHROMA_NEUTRAL = 10'd512;

  // Ceiling log2 for elaboration-time widths.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 32'd1;
    return r;
  endfunction

endpackage

// File: rtl/conv_tap_addr.sv
// Clamped (edge-replicate) read-address generator for one kernel tap.
// Address is registered; it only updates when en_i is high.
module conv_tap_addr import conv_pkg::*; #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned XW     = 10,
  parameter int unsigned YW     = 9,
  parameter int unsigned TAPS   = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en_i,
  input  logic [XW-1:0]            x_i,
  input  logic [YW-1:0]            y_i,
  input  logic [clog2(TAPS)-1:0]   tap_i,
  input  logic                     mode_i,
  output logic [XW+YW-1:0]         read_addr_o
);

  localparam int unsigned SW = ((XW > YW) ? XW : YW) + 2;

  logic signed [SW-1:0] off_c, cx_c, cy_c;
  logic [XW-1:0]        ax_c;
  logic [YW-1:0]        ay_c;
  logic [XW+YW-1:0]     read_addr_q;

  // Signed offset applied along the selected axis, then clamped into the frame.
  always_comb begin
    off_c = $signed(SW'(tap_i)) - $signed(SW'(TAPS / 2));
    cx_c  = $signed(SW'(x_i));
    cy_c  = $signed(SW'(y_i));
    if (mode_i) cy_c = cy_c + off_c;
    else        cx_c = cx_c + off_c;

    if (cx_c[SW-1])                           ax_c = '0;
    else if (cx_c > $signed(SW'(WIDTH - 1)))  ax_c = XW'(WIDTH - 1);
    else                                      ax_c = XW'(cx_c);

    if (cy_c[SW-1])                           ay_c = '0;
    else if (cy_c > $signed(SW'(HEIGHT - 1))) ay_c = YW'(HEIGHT - 1);
    else                                      ay_c = YW'(cy_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     read_addr_q <= '0;
    else if (en_i) read_addr_q <= {ay_c, ax_c};
  end

  assign read_addr_o = read_addr_q;

endmodule

// File: rtl/kernel_convolver.sv
// 1-D separable luma convolver with clamped borders over a raster-scanned frame.
// Define CONV_CHROMA_KEEP_EN to pass the centre pixel's Cr/Cb through; otherwise output is grayscale.
module kernel_convolver import conv_pkg::*; #(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned XW         = 10,
  parameter int unsigned YW         = 9,
  parameter int unsigned TAPS       = 5,
  parameter int unsigned COEF_SHIFT = 8,
  parameter int unsigned READ_LAT   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [TAPS*COEF_W-1:0]   coef,
  output logic                     busy,
  output logic                     done,
  output logic [XW+YW-1:0]         read_addr,
  input  logic [35:0]              read_data,
  output logic [XW+YW-1:0]         write_addr,
  output logic [35:0]              write_data,
  output logic                     write_en
);

  localparam int unsigned TW       = clog2(TAPS);
  localparam int unsigned CNT_W    = clog2(TAPS + READ_LAT);
  localparam int unsigned ACC_W    = PIX_W + COEF_W + clog2(TAPS);
  localparam int unsigned PROD_W   = PIX_W + COEF_W;
  localparam int unsigned RW       = ACC_W + 1;
  localparam int unsigned AW       = XW + YW;
  localparam int unsigned RND_HALF = 1 << (COEF_SHIFT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS + READ_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_TAPS = CNT_W'(TAPS);
  localparam logic [PIX_W-1:0] PIX_SAT  = '1;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [XW-1:0]             x_q, x_d;
  logic [YW-1:0]             y_q, y_d;
  logic                      mode_q, mode_d;
  logic [TAPS*COEF_W-1:0]    coef_q, coef_d;
  logic [ACC_W-1:0]          acc_q, acc_d, acc_mac;
  logic [READ_LAT-1:0]       dl_vld_q;
  logic [TW-1:0]             dl_idx_q [READ_LAT];
  logic                      busy_q, busy_d, done_q, done_d, wen_q, wen_d;
  logic [AW-1:0]             waddr_q, waddr_d;
  logic [35:0]               wdata_q, wdata_d;
  logic                      issue_now, issue_d, last_px;
  logic [COEF_W-1:0]         tap_coef;
  logic [PROD_W-1:0]         prod;
  logic [RW-1:0]             rnd, rnd_sh;
  logic [PIX_W-1:0]          y_out, cr_out, cb_out;
  logic                      unused_rd;

`ifdef CONV_CHROMA_KEEP_EN
  logic [PIX_W-1:0]          cr_q, cr_d, cb_q, cb_d;
  assign unused_rd = ^read_data[35:30];
`else
  assign unused_rd = ^{read_data[35:30], read_data[19:0]};
`endif

  assign issue_now = (state_q == FETCH) && (cnt_q < CNT_TAPS);
  assign last_px   = (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));

  // MAC on the tap whose read data arrives this cycle, plus round/saturate.
  always_comb begin
    tap_coef = coef_q[COEF_W*dl_idx_q[READ_LAT-1] +: COEF_W];
    prod     = PROD_W'(tap_coef) * PROD_W'(read_data[29:20]);
    acc_mac  = dl_vld_q[READ_LAT-1] ? acc_q + ACC_W'(prod) : acc_q;
    rnd      = RW'(acc_mac) + RW'(RND_HALF);
    rnd_sh   = rnd >> COEF_SHIFT;
    y_out    = (rnd_sh > RW'(PIX_SAT)) ? PIX_SAT : PIX_W'(rnd_sh);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    coef_d  = coef_q;
    acc_d   = acc_mac;
    done_d  = 1'b0;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef CONV_CHROMA_KEEP_EN
    cr_d = cr_q;
    cb_d = cb_q;
    if (dl_vld_q[READ_LAT-1] && (dl_idx_q[READ_LAT-1] == TW'(TAPS / 2))) begin
      cr_d = read_data[19:10];
      cb_d = read_data[9:0];
    end
    cr_out = cr_d;
    cb_out = cb_d;
`else
    cr_out = CHROMA_NEUTRAL;
    cb_out = CHROMA_NEUTRAL;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          state_d = FETCH;
          mode_d  = mode;
          coef_d  = coef;
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      FETCH: begin
        if (cnt_q == CNT_LAST) begin
          state_d = WRITE;
          cnt_d   = '0;
          wen_d   = 1'b1;
          waddr_d = {y_q, x_q};
          wdata_d = {6'b0, y_out, cr_out, cb_out};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE: begin
        acc_d = '0;
        if (last_px) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = FETCH;
          if (x_q == XW'(WIDTH - 1)) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == FETCH) || (state_d == WRITE);
    issue_d = (state_d == FETCH) && (cnt_d < CNT_TAPS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      mode_q   <= 1'b0;
      coef_q   <= '0;
      acc_q    <= '0;
      dl_vld_q <= '0;
      for (int i = 0; i < int'(READ_LAT); i++) dl_idx_q[i] <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
`ifdef CONV_CHROMA_KEEP_EN
      cr_q     <= '0;
      cb_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      mode_q      <= mode_d;
      coef_q      <= coef_d;
      acc_q       <= acc_d;
      // Tap-index delay line matches each read with its coefficient READ_LAT cycles later.
      dl_vld_q[0] <= issue_now;
      dl_idx_q[0] <= issue_now ? TW'(cnt_q) : '0;
      for (int i = 1; i < int'(READ_LAT); i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_idx_q[i] <= dl_idx_q[i-1];
      end
      busy_q      <= busy_d;
      done_q      <= done_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
`ifdef CONV_CHROMA_KEEP_EN
      cr_q        <= cr_d;
      cb_q        <= cb_d;
`endif
    end
  end

  conv_tap_addr #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .XW    (XW),
    .YW    (YW),
    .TAPS  (TAPS)
  ) u_tap_addr (
    .clk        (clk),
    .reset      (reset),
    .en_i       (issue_d),
    .x_i        (x_d),
    .y_i        (y_d),
    .tap_i      (TW'(cnt_d)),
    .mode_i     (mode_d),
    .read_addr_o(read_addr)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign write_en   = wen_q;
  assign write_addr = waddr_q;
  assign write_data = wdata_q;

endmodule

// File: tb/tb_kernel_convolver.sv
// Directed + randomized bench for kernel_convolver on a small 16x8 frame,
// checked against an arithmetic convolution model with clamped borders.
module tb_kernel_convolver;

  localparam int W = 16, H = 8, XW = 10, YW = 9, TAPS = 5, SH = 8, RL = 2;
  localparam int CW = TAPS * 8, AW = XW + YW;
  localparam int BUDGET = W * H * (TAPS + RL + 1) + 200;

  logic          clk = 1'b0;
  logic          reset, start, mode;
  logic [CW-1:0] coef;
  logic          busy, done, write_en;
  logic [AW-1:0] read_addr, write_addr;
  logic [35:0]   read_data, write_data, rd_s1;

  int checks = 0, failures = 0;
  logic [9:0] img_y [H][W];
  logic [9:0] img_cr[H][W];
  logic [9:0] img_cb[H][W];
  int oy[H][W], ocr[H][W], ocb[H][W];
  int wr_cnt, done_cnt, order_err, bad_addr, exp_i;

  always #5 clk = ~clk;

  kernel_convolver #(
    .WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .TAPS(TAPS), .COEF_SHIFT(SH), .READ_LAT(RL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .coef(coef),
    .busy(busy), .done(done), .read_addr(read_addr), .read_data(read_data),
    .write_addr(write_addr), .write_data(write_data), .write_en(write_en)
  );

  function automatic logic [35:0] mem_word(input logic [AW-1:0] a);
    int x, y;
    x = int'(a[XW-1:0]);
    y = int'(a[AW-1:XW]);
    if (x >= W || y >= H) return 36'h0;
    return {6'b0, img_y[y][x], img_cr[y][x], img_cb[y][x]};
  endfunction

  // Frame buffer with two cycles of read latency.
  always @(posedge clk) begin
    rd_s1     <= mem_word(read_addr);
    read_data <= rd_s1;
  end

  // Output capture and protocol observation.
  always @(negedge clk) begin
    int xa, ya;
    if (write_en === 1'b1) begin
      xa = int'(write_addr[XW-1:0]);
      ya = int'(write_addr[AW-1:XW]);
      if (xa < W && ya < H) begin
        oy[ya][xa]  = int'(write_data[29:20]);
        ocr[ya][xa] = int'(write_data[19:10]);
        ocb[ya][xa] = int'(write_data[9:0]);
      end else order_err++;
      if (ya * W + xa != exp_i) order_err++;
      if (write_data[35:30] !== 6'b0) order_err++;
      exp_i++;
      wr_cnt++;
    end
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1 && (int'(read_addr[XW-1:0]) >= W || int'(read_addr[AW-1:XW]) >= H))
      bad_addr++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: weighted sum of clamped neighbours, rounded, shifted, saturated.
  function automatic int ref_y(input int x, input int y, input logic m, input logic [CW-1:0] c);
    int acc, xx, yy, r;
    logic [CW-1:0] cv;
    cv = c;
    acc = 0;
    for (int k = 0; k < TAPS; k++) begin
      xx = m ? x : x + k - TAPS / 2;
      yy = m ? y + k - TAPS / 2 : y;
      if (xx < 0) xx = 0;
      if (xx > W - 1) xx = W - 1;
      if (yy < 0) yy = 0;
      if (yy > H - 1) yy = H - 1;
      acc += int'(cv[8*k +: 8]) * int'(img_y[yy][xx]);
    end
    r = (acc + (1 << (SH - 1))) >> SH;
    return (r > 1023) ? 1023 : r;
  endfunction

  task automatic clear_capture();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        oy[y][x] = -1; ocr[y][x] = -1; ocb[y][x] = -1;
      end
    wr_cnt = 0; done_cnt = 0; order_err = 0; bad_addr = 0; exp_i = 0;
  endtask

  task automatic fill(input int yval, input bit rnd);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        img_y[y][x]  = rnd ? 10'($urandom_range(0, 1023)) : 10'(yval);
        img_cr[y][x] = 10'($urandom_range(0, 1023));
        img_cb[y][x] = 10'($urandom_range(0, 1023));
      end
  endtask

  function automatic logic [CW-1:0] rand_coef();
    logic [CW-1:0] c;
    for (int k = 0; k < TAPS; k++) c[8*k +: 8] = 8'($urandom_range(0, 255));
    return c;
  endfunction

  task automatic kick(input logic m, input logic [CW-1:0] c, input string tag);
    mode = m; coef = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    while (!seen && n < BUDGET) begin
      @(negedge clk);
      #1;
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    if (seen) check({tag, " busy_low_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic check_frame(input string tag, input logic m, input logic [CW-1:0] c);
    int errs, ey, ecr, ecb;
    string first;
    errs = 0; first = "";
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        ey = ref_y(x, y, m, c);
`ifdef CONV_CHROMA_KEEP_EN
        ecr = int'(img_cr[y][x]); ecb = int'(img_cb[y][x]);
`else
        ecr = 512; ecb = 512;
`endif
        if (oy[y][x] != ey || ocr[y][x] != ecr || ocb[y][x] != ecb) begin
          if (errs == 0)
            first = $sformatf("first@(%0d,%0d) y=%0d/%0d cr=%0d/%0d", x, y, oy[y][x], ey, ocr[y][x], ecr);
          errs++;
        end
      end
    check({tag, " pixel_errors ", first}, 64'(errs), 64'd0);
    check({tag, " write_count"}, 64'(wr_cnt), 64'(W * H));
    check({tag, " order_errors"}, 64'(order_err), 64'd0);
    check({tag, " bad_read_addr"}, 64'(bad_addr), 64'd0);
    check({tag, " done_count"}, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    logic [CW-1:0] cg, c1, c2, csat;
    int wr_before;
    cg   = {8'd16, 8'd64, 8'd96, 8'd64, 8'd16};
    csat = '1;
    reset = 1'b1; start = 1'b0; mode = 1'b0; coef = '0;
    fill(0, 1'b0);
    clear_capture();

    // Reset values
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset write_en", 64'(write_en), 64'd0);
    check("reset read_addr", 64'(read_addr), 64'd0);
    check("reset write_addr", 64'(write_addr), 64'd0);
    check("reset write_data", 64'(write_data), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Constant frame
    fill(400, 1'b0);
    clear_capture();
    kick(1'b0, cg, "const");
    wait_done("const");
    check_frame("const", 1'b0, cg);
    check("const y00", 64'(oy[0][0]), 64'd400);
    check("const ylast", 64'(oy[H-1][W-1]), 64'd400);
    repeat (3) @(negedge clk);
    #1;
    check("const single_done", 64'(done_cnt), 64'd1);

    // Random horizontal, then back-to-back random vertical started in the DONE cycle
    @(negedge clk);
    fill(0, 1'b1);
    c1 = rand_coef();
    clear_capture();
    kick(1'b0, c1, "rand_h");
    wait_done("rand_h");
    check_frame("rand_h", 1'b0, c1);
    fill(0, 1'b1);
    c2 = rand_coef();
    clear_capture();
    kick(1'b1, c2, "rand_v_b2b");
    wait_done("rand_v_b2b");
    check_frame("rand_v_b2b", 1'b1, c2);

    // Horizontal impulse
    @(negedge clk);
    fill(0, 1'b0);
    img_y[5][10] = 10'd1000;
    clear_capture();
    kick(1'b0, cg, "imp_h");
    wait_done("imp_h");
    check_frame("imp_h", 1'b0, cg);
    check("imp_h x8", 64'(oy[5][8]), 64'd63);
    check("imp_h x9", 64'(oy[5][9]), 64'd250);
    check("imp_h x10", 64'(oy[5][10]), 64'd375);
    check("imp_h x11", 64'(oy[5][11]), 64'd250);
    check("imp_h x12", 64'(oy[5][12]), 64'd63);
    check("imp_h x7", 64'(oy[5][7]), 64'd0);

    // Vertical impulse
    @(negedge clk);
    clear_capture();
    kick(1'b1, cg, "imp_v");
    wait_done("imp_v");
    check_frame("imp_v", 1'b1, cg);
    check("imp_v y3", 64'(oy[3][10]), 64'd63);
    check("imp_v y4", 64'(oy[4][10]), 64'd250);
    check("imp_v y5", 64'(oy[5][10]), 64'd375);
    check("imp_v y6", 64'(oy[6][10]), 64'd250);
    check("imp_v y7", 64'(oy[7][10]), 64'd63);
    check("imp_v row5_x9", 64'(oy[5][9]), 64'd0);

    // Left-edge clamp: taps left of x=0 replicate the corner pixel
    @(negedge clk);
    fill(0, 1'b0);
    img_y[0][0] = 10'd1000;
    clear_capture();
    kick(1'b0, cg, "edge");
    wait_done("edge");
    check_frame("edge", 1'b0, cg);
    check("edge x0", 64'(oy[0][0]), 64'd688);
    check("edge x1", 64'(oy[0][1]), 64'd313);
    check("edge x2", 64'(oy[0][2]), 64'd63);

    // Saturation
    @(negedge clk);
    fill(1023, 1'b0);
    clear_capture();
    kick(1'b0, csat, "sat");
    wait_done("sat");
    check_frame("sat", 1'b0, csat);
    check("sat y", 64'(oy[3][7]), 64'd1023);

    // Start pulses while busy carry different mode/coef and must be ignored
    @(negedge clk);
    fill(0, 1'b1);
    c1 = rand_coef();
    c2 = rand_coef();
    clear_capture();
    kick(1'b0, c1, "abuse");
    repeat (300) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mode = 1'b1; coef = c2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (37) @(negedge clk);
    end
    wait_done("abuse");
    check_frame("abuse", 1'b0, c1);

    // Reset mid-frame aborts with no further writes and no done
    @(negedge clk);
    clear_capture();
    kick(1'b0, c1, "midrst");
    repeat (200) @(negedge clk);
    #1;
    wr_before = wr_cnt;
    reset = 1'b1;
    #1;
    check("midrst write_en", 64'(write_en), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("midrst writes_after", 64'(wr_cnt), 64'(wr_before));
    check("midrst no_done", 64'(done_cnt), 64'd0);
    check("midrst partial", 64'(wr_before > 0), 64'd1);

    // Fresh full frame after the abort
    @(negedge clk);
    clear_capture();
    kick(1'b0, c1, "fresh");
    wait_done("fresh");
    check_frame("fresh", 1'b0, c1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
